// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    // Active-low segment patterns {g,f,e,d,c,b,a}, indexed by hex digit.
    localparam logic [6:0] SEG_HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Bits needed to hold 0..n-1; never less than 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex digit to active-low segment pattern.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Table lookup of the segment pattern.
    always_comb begin
        seg = SEG_HEX[hex];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver with inter-digit blanking
// and optional leading-zero suppression.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLANK_CYC   = 16,
    parameter int unsigned LEAD_BLANK  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic        load,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [1:0]  digit_sel
);

    localparam int unsigned    CNT_W     = clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC);

    logic [15:0]      shown_q;
    logic [CNT_W-1:0] div_cnt;
    logic [1:0]       idx;
    logic [3:0]       nibble;
    logic [15:0]      upper;
    logic             digit_blank;
    logic [6:0]       dec_seg;
    logic [3:0]       an_d;
    logic [6:0]       seg_d;

    assign dp        = 1'b1;
    assign digit_sel = idx;

    // Capture the display word on load.
    always_ff @(posedge clk) begin
        if (reset) begin
            shown_q <= '0;
        end else if (load) begin
            shown_q <= value;
        end
    end

    // Slot divider and digit index; idx advances on the divider wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            idx     <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            idx     <= idx + 2'd1;
        end else begin
            div_cnt <= div_cnt + CNT_W'(1);
        end
    end

    // Select the current nibble and decide whether it is a leading zero.
    always_comb begin
        nibble      = shown_q[{idx, 2'b00} +: 4];
        upper       = shown_q >> {idx, 2'b00};
        digit_blank = (LEAD_BLANK != 0) && (idx != 2'd0) && (upper == 16'h0000);
    end

    seg7_hex_decode u_decode (
        .hex (nibble),
        .seg (dec_seg)
    );

    // Next anode/segment values: dark during the blank window or for a suppressed digit.
    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        if ((div_cnt >= BLANK_LIM) && !digit_blank) begin
            an_d  = ~(4'b0001 << idx);
            seg_d = dec_seg;
        end
    end

    // Registered display outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
        end else begin
            an  <= an_d;
            seg <= seg_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench: driver pushes expected outputs, monitor pops and compares.
module tb_seg7_scan_driver;

    localparam int unsigned DIV   = 4;
    localparam int unsigned BLANK = 1;

    logic        clk;
    logic        reset;
    logic [15:0] value;
    logic        load;
    logic [3:0]  an, an_nb;
    logic [6:0]  seg, seg_nb;
    logic        dp, dp_nb;
    logic [1:0]  digit_sel, digit_sel_nb;

    seg7_scan_driver #(.REFRESH_DIV(4), .BLANK_CYC(1), .LEAD_BLANK(1)) dut (
        .clk(clk), .reset(reset), .value(value), .load(load),
        .an(an), .seg(seg), .dp(dp), .digit_sel(digit_sel)
    );

    seg7_scan_driver #(.REFRESH_DIV(4), .BLANK_CYC(1), .LEAD_BLANK(0)) dut_nb (
        .clk(clk), .reset(reset), .value(value), .load(load),
        .an(an_nb), .seg(seg_nb), .dp(dp_nb), .digit_sel(digit_sel_nb)
    );

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic [3:0] an_nb;
        logic [6:0] seg_nb;
        logic [1:0] sel;
    } exp_t;

    exp_t q[$];

    logic [6:0] hex_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Reference model state: cycles counted since reset, and the word on display.
    int unsigned c;
    logic [15:0] shown;

    int checks;
    int errors;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Display a cycle would produce, from elapsed count and the shown word.
    function automatic void expect_out(input int unsigned cyc, input logic [15:0] s, input bit lead,
                                       output logic [3:0] a, output logic [6:0] g);
        int unsigned pos;
        int unsigned d;
        logic [15:0] hi;
        logic [3:0] nib;
        pos = cyc % DIV;
        d   = (cyc / DIV) % 4;
        hi  = s >> (4 * d);
        nib = hi[3:0];
        a   = 4'b1111;
        g   = 7'b1111111;
        if (pos >= BLANK && !(lead && d > 0 && hi == 16'h0000)) begin
            a = ~(4'b0001 << d);
            g = hex_tab[nib];
        end
    endfunction

    task automatic step(input bit r, input bit ld, input logic [15:0] v);
        exp_t e;
        @(negedge clk);
        reset = r;
        load  = ld;
        value = v;
        if (r) begin
            e.an = 4'b1111; e.seg = 7'b1111111;
            e.an_nb = 4'b1111; e.seg_nb = 7'b1111111;
            e.sel = 2'd0;
            c = 0;
            shown = 16'h0000;
        end else begin
            expect_out(c, shown, 1'b1, e.an, e.seg);
            expect_out(c, shown, 1'b0, e.an_nb, e.seg_nb);
            if (ld) shown = v;
            c++;
            e.sel = 2'((c / DIV) % 4);
        end
        q.push_back(e);
    endtask

    // Monitor: outputs are valid every cycle once driving starts.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("an",        16'(an),           16'(e.an));
                chk("seg",       16'(seg),          16'(e.seg));
                chk("dp",        16'(dp),           16'h1);
                chk("digit_sel", 16'(digit_sel),    16'(e.sel));
                chk("an_nb",     16'(an_nb),        16'(e.an_nb));
                chk("seg_nb",    16'(seg_nb),       16'(e.seg_nb));
                chk("dp_nb",     16'(dp_nb),        16'h1);
                chk("sel_nb",    16'(digit_sel_nb), 16'(e.sel));
                if (an != 4'b1111 && an != 4'b1110 && an != 4'b1101 && an != 4'b1011 && an != 4'b0111) begin
                    chk("one_hot_an", 16'(an), 16'hF);
                end
            end
        end
    end

    initial begin
        logic [15:0] dir_vals [4];
        logic [15:0] rv;
        checks = 0;
        errors = 0;
        c = 0;
        shown = 16'h0000;
        reset = 1'b1;
        load  = 1'b1;
        value = 16'hFFFF;
        dir_vals[0] = 16'h1234;
        dir_vals[1] = 16'h0005;
        dir_vals[2] = 16'h0000;
        dir_vals[3] = 16'hABCD;

        // Reset with load active must not capture.
        step(1'b1, 1'b1, 16'hFFFF);
        step(1'b1, 1'b1, 16'hFFFF);

        // Directed words: one load, then a full scan with changing but unloaded value.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, dir_vals[i]);
            for (int j = 0; j < 16; j++) begin
                step(1'b0, 1'b0, 16'($urandom));
            end
        end

        // Mid-slot load during the second lit cycle of slot 2.
        while ((c % 16) != 10) step(1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 16'h0F00);
        for (int j = 0; j < 3; j++) step(1'b0, 1'b0, 16'h0000);

        // Reset in the middle of slot 3.
        while ((c % 16) != 13) step(1'b0, 1'b0, 16'h0000);
        step(1'b1, 1'b0, 16'h0000);
        for (int j = 0; j < 8; j++) step(1'b0, 1'b0, 16'h0000);

        // Randomized loads with words biased toward leading zeros, occasional reset.
        for (int i = 0; i < 400; i++) begin
            rv = 16'($urandom) >> (4 * $urandom_range(0, 4));
            step($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0, rv);
        end

        step(1'b0, 1'b0, 16'h0000);
        repeat (3) @(posedge clk);
        #2;
        chk("drain", 16'(q.size()), 16'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Downstream consumer of the core's 16-bit `showbasys` debug word.
- Drives the Basys 4-digit multiplexed seven-segment display as four hex digits.
- Time-multiplexes the digits with a refresh divider, blanks the anodes briefly between digits to prevent ghosting, and optionally suppresses leading zeros.
- Instantiated at board top level beside the core.

Parameters:
- REFRESH_DIV, 100000, clk cycles per digit slot (100 MHz gives 1 kHz per digit); legal range 2..2^20.
- BLANK_CYC, 16, cycles at the start of each slot with all anodes off; must be < REFRESH_DIV.
- LEAD_BLANK, 1, 1 suppresses leading zero digits, 0 shows all four digits.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high.
- value  input  16  word to display; bits [3:0] map to the rightmost digit.
- load  input  1  when high at a clk edge, value is captured into shown_q.
- an  output  4  anode enables, active-low; an[0] is the rightmost digit.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low; held 1 (off).
- digit_sel  output  2  current slot index, for debug.

Behaviour:
- Reset (synchronous, active-high) sets: shown_q=0, div_cnt=0, idx=0, an=4'b1111, seg=7'b1111111, dp=1, digit_sel=0. Reset has priority over load and over counting, including mid-slot.
- Capture: load=1 at edge N sets shown_q=value after edge N. seg and an reflect the new shown_q from edge N+1 (one registered output stage).
- Divider: div_cnt counts 0..REFRESH_DIV-1 and then wraps to 0. On the wrap edge, idx increments 0→1→2→3→0 (2-bit natural wrap). digit_sel=idx.
- Output register, updated every edge from the current div_cnt, idx and shown_q:
  - if div_cnt < BLANK_CYC: an=4'b1111, seg=7'b1111111;
  - else if digit idx is blanked: an=4'b1111, seg=7'b1111111;
  - else: an=~(4'b0001<<idx), seg=hex_to_seg(shown_q[4*idx+3:4*idx]).
- Leading-zero blanking (LEAD_BLANK=1):
  - digit k (k=3,2,1) is blanked iff shown_q[15:4k]==0;
  - digit 0 is never blanked, so value 0 displays "0".
  - LEAD_BLANK=0 means no digit is ever blanked.
- Exactly one anode low at most, in every cycle.
- Load during a slot never restarts div_cnt or idx; the new digit data appears mid-slot.
- Decode table (hex→seg):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- No handshake back to the producer. Load may be tied high for continuous follow.

Decomposition:
- Shared package seg7_pkg holds:
  - the 16-entry SEG_HEX constant table;
  - SEG_OFF=7'b1111111 and AN_OFF=4'b1111;
  - the divider width function clog2(REFRESH_DIV).
- One combinational sub-module, seg7_hex_decode (4-bit in, 7-bit seg out), indexes SEG_HEX.
- Divider, slot index, blanking logic and output register stay in seg7_scan_driver.

Test Plan (REFRESH_DIV=4, BLANK_CYC=1, LEAD_BLANK=1 unless stated):
- Hold reset for 2 edges with load=1 and value=16'hFFFF → an=1111, seg=1111111, dp=1, digit_sel=0, shown_q=0. Then release reset.
- load=1 with value=16'h1234, then run 16 cycles → each 4-cycle slot shows 1 blanked cycle then 3 lit cycles:
  - idx0: an=1110, seg=0011001 ("4");
  - idx1: an=1101, seg=0110000 ("3");
  - idx2: an=1011, seg=0100100 ("2");
  - idx3: an=0111, seg=1111001 ("1");
  - then digit_sel wraps to 0.
- load with value=16'h0005 → only slot 0 lights, an=1110 and seg=0010010. Slots 1–3 keep an=1111. Repeat with LEAD_BLANK=0 → slots 1–3 light with seg=1000000.
- load with value=16'h0000 → slot 0 shows seg=1000000. Load with value=16'hABCD → slots 0..3 show d, C, b, A per the table.
- In the 2nd lit cycle of slot 2, pulse load with value=16'h0F00 → the next edge shows seg=0001110 on an=1011. div_cnt and idx are undisturbed.
- Assert reset mid-slot 3 for 1 edge → all outputs return to their reset values on that edge. Scanning restarts at idx0, whose first cycle is blanked.
